// File: rtl/sisc_fetch_unit.sv
// rtl/sisc_fetch_unit.sv - SISC instruction fetch stage: PC/IR ownership, imem handshake, branch resolution
module sisc_fetch_unit #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              IMEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            fetch_go,
  input  logic            pc_write,
  input  logic [3:0]      stat,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [PC_W-1:0] pc,
  output logic            fetch_done,
  output logic            busy,
  output logic            fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

  localparam int              CNT_W    = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  state_t          state;
  logic [CNT_W-1:0] wait_cnt;
  logic            cond;
  logic [31:0]     imm_sx;
  logic [PC_W-1:0] pc_br;

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign busy   = (state != IDLE);
  assign cond   = |(mm & stat);
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  // Branch target from the current IR; pc already points past the branch.
  always_comb begin
    pc_br = pc;
    case (opcode)
      4'd4:    if (cond)  pc_br = imm_sx[PC_W-1:0];
      4'd5:    if (cond)  pc_br = pc + imm_sx[PC_W-1:0];
      4'd6:    if (!cond) pc_br = imm_sx[PC_W-1:0];
      default: pc_br = pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_write) pc <= pc_br;
          // A simultaneous pc_write redirects this very fetch.
          if (fetch_go) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_write ? pc_br : pc;
            wait_cnt  <= '0;
          end
        end
        REQ: begin
          if (fetch_go || pc_write) fetch_err <= 1'b1;
          if (imem_ack) begin
            ir         <= imem_rdata;
            pc         <= pc + PC_ONE;
            imem_req   <= 1'b0;
            fetch_done <= 1'b1;
            state      <= LOAD;
          end else if (wait_cnt == CNT_LAST) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          if (fetch_go || pc_write) fetch_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb/tb_sisc_fetch_unit.sv - directed self-checking bench for sisc_fetch_unit
module tb_sisc_fetch_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        fetch_go = 1'b0;
  logic        pc_write = 1'b0;
  logic [3:0]  stat = 4'd0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  int vecs = 0;
  int miss = 0;
  bit run = 1'b0;

  logic [15:0] m_pc = 16'd0;
  logic [31:0] m_ir = 32'd0;
  logic        m_err = 1'b0;
  logic [15:0] m_addr = 16'd0;

  sisc_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .pc_write(pc_write), .stat(stat),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .opcode(opcode), .mm(mm), .pc(pc), .fetch_done(fetch_done), .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] br_target(input logic [15:0] p, input logic [31:0] i,
                                            input logic [3:0] s);
    bit cond;
    int t;
    cond = ((i[27:24] & s) != 4'd0);
    t = int'(p) + int'($signed(i[15:0]));
    case (i[31:28])
      4'd4:    return cond ? i[15:0] : p;
      4'd5:    return cond ? 16'(t) : p;
      4'd6:    return cond ? p : i[15:0];
      default: return p;
    endcase
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("pc", {16'd0, pc}, {16'd0, m_pc});
      chk("ir", ir, m_ir);
      chk("opcode", {28'd0, opcode}, {28'd0, m_ir[31:28]});
      chk("mm", {28'd0, mm}, {28'd0, m_ir[27:24]});
      chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    end
  end

  // mode: 0 plain, 1 pc_write together with fetch_go, 2 extra fetch_go while busy,
  // 3 pc_write while busy. lat = cycles imem_req is high, ack in the last one.
  task automatic fetch(input logic [31:0] data, input int lat, input int mode, input logic [3:0] st);
    fetch_go = 1'b1;
    if (mode == 1) begin pc_write = 1'b1; stat = st; end
    @(posedge clk);
    if (mode == 1) m_pc = br_target(m_pc, m_ir, st);
    m_addr = m_pc;
    #1 fetch_go = 1'b0; pc_write = 1'b0;
    for (int i = 0; i < lat; i++) begin
      chk("req_hi", {31'd0, imem_req}, 32'd1);
      chk("addr", {16'd0, imem_addr}, {16'd0, m_addr});
      chk("busy_req", {31'd0, busy}, 32'd1);
      chk("done_lo", {31'd0, fetch_done}, 32'd0);
      if (i == lat - 1) begin imem_ack = 1'b1; imem_rdata = data; end
      else begin
        imem_rdata = $urandom;
        if (i == 0 && mode == 2) fetch_go = 1'b1;
        if (i == 0 && mode == 3) begin pc_write = 1'b1; stat = st; end
      end
      @(posedge clk);
      if (i == lat - 1) begin m_ir = data; m_pc = m_pc + 16'd1; end
      if (i == 0 && mode >= 2) m_err = 1'b1;
      #1 imem_ack = 1'b0; fetch_go = 1'b0; pc_write = 1'b0;
    end
    chk("done_pulse", {31'd0, fetch_done}, 32'd1);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    chk("busy_load", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_once", {31'd0, fetch_done}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("req_idle", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic branch(input logic [3:0] st, input logic [15:0] exp_pc);
    stat = st;
    pc_write = 1'b1;
    @(posedge clk);
    m_pc = br_target(m_pc, m_ir, st);
    #1 pc_write = 1'b0;
    chk("br_pc_lit", {16'd0, pc}, {16'd0, exp_pc});
    chk("model_pin", {16'd0, m_pc}, {16'd0, exp_pc});
  endtask

  task automatic do_reset();
    rst_f = 1'b1;
    m_pc = 16'd0; m_ir = 32'd0; m_err = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_f = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ir", ir, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'd0);
    chk("rst_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    run = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst_f = 1'b0;
    @(posedge clk); #1;

    fetch(32'h8112_0003, 1, 0, 4'd0);
    chk("t1_ir", ir, 32'h8112_0003);
    chk("t1_op", {28'd0, opcode}, 32'd8);
    chk("t1_mm", {28'd0, mm}, 32'd1);
    chk("t1_pc", {16'd0, pc}, 32'd1);

    fetch(32'h4200_0010, 5, 0, 4'd0);
    branch(4'b0000, 16'h0002);
    branch(4'b0010, 16'h0010);

    fetch(32'h4F00_0004, 2, 0, 4'd0);
    branch(4'hF, 16'h0004);
    fetch(32'h5100_FFFC, 1, 0, 4'd0);
    branch(4'b0001, 16'h0001);

    fetch(32'h4F00_FFFE, 1, 0, 4'd0);
    branch(4'hF, 16'hFFFE);
    fetch(32'h5100_0002, 1, 0, 4'd0);
    branch(4'b0001, 16'h0001);

    fetch(32'h6F00_0020, 1, 0, 4'd0);
    branch(4'b0001, 16'h0002);
    branch(4'b0000, 16'h0020);

    fetch(32'hF1F0_0099, 1, 0, 4'd0);
    branch(4'hF, 16'h0021);

    fetch(32'h4F00_0030, 1, 0, 4'd0);
    fetch(32'h8000_0000, 1, 1, 4'hF);
    chk("sim_addr", {16'd0, imem_addr}, 32'h0030);
    chk("sim_pc", {16'd0, pc}, 32'h0031);

    // Timeout: no ack for TO cycles
    fetch_go = 1'b1;
    @(posedge clk); m_addr = m_pc;
    #1 fetch_go = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to_req", {31'd0, imem_req}, 32'd1);
      chk("to_addr", {16'd0, imem_addr}, {16'd0, m_addr});
      imem_rdata = $urandom;
      @(posedge clk);
      if (i == TO - 1) m_err = 1'b1;
      #1;
    end
    chk("to_req_lo", {31'd0, imem_req}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_done", {31'd0, fetch_done}, 32'd0);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_pc", {16'd0, pc}, 32'h0031);

    do_reset();
    fetch(32'h4F00_0040, 1, 0, 4'd0);
    fetch(32'h0000_1111, 3, 3, 4'hF);
    chk("pwbusy_pc", {16'd0, pc}, 32'h0002);
    chk("pwbusy_err", {31'd0, fetch_err}, 32'd1);

    do_reset();
    fetch(32'h0123_4567, 4, 2, 4'd0);
    chk("dup_pc", {16'd0, pc}, 32'h0001);
    chk("dup_err", {31'd0, fetch_err}, 32'd1);
    @(posedge clk); #1;
    chk("dup_no_req", {31'd0, imem_req}, 32'd0);

    do_reset();
    fetch(32'h1234_5678, 1, 0, 4'd0);
    fetch_go = 1'b1;
    @(posedge clk);
    #1 fetch_go = 1'b0;
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;
    rst_f = 1'b1;
    m_pc = 16'd0; m_ir = 32'd0; m_err = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_pc", {16'd0, pc}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_f = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 imem_ack = 1'b0;
    chk("late_ack_done", {31'd0, fetch_done}, 32'd0);
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_ir", ir, 32'd0);
    @(posedge clk); #1;

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
